ldl_round_req: RTL and testbench

LDL_ROUND_REQ -- requirements
Module: LDL_round_req

---
 rtl/ldl_round_req.sv | 105 ++++++++++
 tb/tb_ldl_round_req.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ldl_round_req.sv
// Per-client pending-request tracker feeding a round-robin priority arbiter.
// Optional request aging (boosts cos of starved clients) via LDL_ROUND_REQ_AGE_EN.
module ldl_round_req #(
  parameter int BIN_WIDTH = 3,
  parameter int COS_WIDTH = 2,
  parameter int CNT_WIDTH = 2,
  parameter int AGE_WIDTH = 4,
  localparam int REQ_WIDTH = 1 << BIN_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_WIDTH-1:0]           push,
  input  logic [REQ_WIDTH*COS_WIDTH-1:0] cos_cfg,
  output logic [REQ_WIDTH-1:0]           req,
  output logic [REQ_WIDTH*COS_WIDTH-1:0] cos,
  input  logic                           ack,
  input  logic [BIN_WIDTH-1:0]           bin,
  output logic [REQ_WIDTH-1:0]           done,
  output logic [REQ_WIDTH-1:0]           ovf,
  output logic                           err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt      [REQ_WIDTH];
  logic [CNT_WIDTH-1:0] cnt_next [REQ_WIDTH];
  logic [REQ_WIDTH-1:0] grant;
  logic [REQ_WIDTH-1:0] ovf_next;
  logic                 err_next;

  always_comb begin
    grant    = '0;
    err_next = 1'b0;
    if (ack) begin
      if (cnt[bin] != '0) grant[bin] = 1'b1;
      else                err_next   = 1'b1;
    end
    for (int k = 0; k < REQ_WIDTH; k++) begin
      cnt_next[k] = cnt[k];
      ovf_next[k] = 1'b0;
      if (push[k] && !grant[k]) begin
        if (cnt[k] == CNT_MAX) ovf_next[k] = 1'b1;
        else                   cnt_next[k] = cnt[k] + CNT_ONE;
      end else if (grant[k] && !push[k]) begin
        cnt_next[k] = cnt[k] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < REQ_WIDTH; k++) cnt[k] <= '0;
      done <= '0;
      ovf  <= '0;
      err  <= 1'b0;
    end else begin
      for (int k = 0; k < REQ_WIDTH; k++) cnt[k] <= cnt_next[k];
      done <= grant;
      ovf  <= ovf_next;
      err  <= err_next;
    end
  end

  always_comb begin
    for (int k = 0; k < REQ_WIDTH; k++) req[k] = (cnt[k] != '0);
  end

`ifdef LDL_ROUND_REQ_AGE_EN
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;
  localparam logic [AGE_WIDTH-1:0] AGE_ONE = AGE_WIDTH'(1);

  logic [AGE_WIDTH-1:0] age      [REQ_WIDTH];
  logic [AGE_WIDTH-1:0] age_next [REQ_WIDTH];

  always_comb begin
    for (int k = 0; k < REQ_WIDTH; k++) begin
      age_next[k] = age[k];
      if (grant[k] || cnt_next[k] == '0)
        age_next[k] = '0;
      else if (req[k] && age[k] != AGE_MAX)
        age_next[k] = age[k] + AGE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < REQ_WIDTH; k++) age[k] <= '0;
    end else begin
      for (int k = 0; k < REQ_WIDTH; k++) age[k] <= age_next[k];
    end
  end

  // A starved client is promoted to the top class until it is served.
  always_comb begin
    cos = cos_cfg;
    for (int k = 0; k < REQ_WIDTH; k++) begin
      if (age[k] == AGE_MAX) cos[k*COS_WIDTH +: COS_WIDTH] = '1;
    end
  end
`else
  assign cos = cos_cfg;
`endif

endmodule

// File: tb/tb_ldl_round_req.sv
// Directed table-driven bench for ldl_round_req, plus a hand-written aging sequence.
module tb_ldl_round_req;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  push;
  logic [15:0] cos_cfg;
  logic [7:0]  req;
  logic [15:0] cos;
  logic        ack;
  logic [2:0]  bin;
  logic [7:0]  done;
  logic [7:0]  ovf;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  ldl_round_req dut (
    .clk(clk), .rst(rst), .push(push), .cos_cfg(cos_cfg), .req(req), .cos(cos),
    .ack(ack), .bin(bin), .done(done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] push;
    logic       ack;
    logic [2:0] bin;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] ovf;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [7:0] p, logic a, logic [2:0] b,
                              logic [7:0] q, logic [7:0] d, logic [7:0] o, logic e);
    vec_t v;
    v.rst = r; v.push = p; v.ack = a; v.bin = b;
    v.req = q; v.done = d; v.ovf = o; v.err = e;
    return v;
  endfunction

  task automatic cycle(input logic r, input logic [7:0] p, input logic a, input logic [2:0] b);
    rst = r; push = p; ack = a; bin = b;
    @(posedge clk);
    #1;
    rst = 1'b0; push = '0; ack = 1'b0; bin = '0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [15:0] cos_aged;

  initial begin
    rst = 1'b1; push = '0; ack = 1'b0; bin = '0;
    // client 1 class 0; client 1 occupies bits [3:2]
    cos_cfg  = 16'h9C72;
    cos_aged = 16'h9C7E;

    //             rst push   ack bin   req    done   ovf    err
    vecs.push_back(mk(1, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0)); // reset state
    vecs.push_back(mk(0, 8'h01, 0, 3'd0, 8'h01, 8'h00, 8'h00, 0)); // push -> req next cycle
    vecs.push_back(mk(0, 8'h00, 1, 3'd0, 8'h00, 8'h01, 8'h00, 0)); // grant -> done, req drops
    vecs.push_back(mk(0, 8'h08, 0, 3'd0, 8'h08, 8'h00, 8'h00, 0)); // cnt3=1
    vecs.push_back(mk(0, 8'h08, 0, 3'd0, 8'h08, 8'h00, 8'h00, 0)); // cnt3=2
    vecs.push_back(mk(0, 8'h08, 0, 3'd0, 8'h08, 8'h00, 8'h00, 0)); // cnt3=3
    vecs.push_back(mk(0, 8'h08, 0, 3'd0, 8'h08, 8'h00, 8'h08, 0)); // 4th push dropped
    vecs.push_back(mk(0, 8'h08, 1, 3'd3, 8'h08, 8'h08, 8'h00, 0)); // push+grant at max: no ovf
    vecs.push_back(mk(0, 8'h00, 1, 3'd3, 8'h08, 8'h08, 8'h00, 0)); // cnt3=2
    vecs.push_back(mk(0, 8'h00, 1, 3'd3, 8'h08, 8'h08, 8'h00, 0)); // cnt3=1
    vecs.push_back(mk(0, 8'h00, 1, 3'd3, 8'h00, 8'h08, 8'h00, 0)); // cnt3=0, req falls
    vecs.push_back(mk(0, 8'h04, 0, 3'd0, 8'h04, 8'h00, 8'h00, 0)); // cnt2=1
    vecs.push_back(mk(0, 8'h04, 1, 3'd2, 8'h04, 8'h04, 8'h00, 0)); // push+grant: stays 1
    vecs.push_back(mk(0, 8'h00, 1, 3'd2, 8'h00, 8'h04, 8'h00, 0)); // drain
    vecs.push_back(mk(0, 8'h00, 1, 3'd5, 8'h00, 8'h00, 8'h00, 1)); // grant to empty -> err
    vecs.push_back(mk(0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0)); // err one cycle only
    vecs.push_back(mk(0, 8'h12, 0, 3'd0, 8'h12, 8'h00, 8'h00, 0)); // two clients at once
    vecs.push_back(mk(0, 8'h00, 1, 3'd5, 8'h12, 8'h00, 8'h00, 1)); // err leaves counters alone
    vecs.push_back(mk(0, 8'h00, 1, 3'd1, 8'h10, 8'h02, 8'h00, 0));
    vecs.push_back(mk(0, 8'h00, 1, 3'd4, 8'h00, 8'h10, 8'h00, 0));
    vecs.push_back(mk(0, 8'hA5, 0, 3'd0, 8'hA5, 8'h00, 8'h00, 0)); // req=A5 pending
    vecs.push_back(mk(0, 8'h00, 1, 3'd7, 8'h25, 8'h80, 8'h00, 0)); // done pending in reset
    vecs.push_back(mk(1, 8'h5A, 1, 3'd0, 8'h00, 8'h00, 8'h00, 0)); // reset mid-operation
    vecs.push_back(mk(0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 8'h00, 0)); // reset-cycle push ignored

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].push, vecs[i].ack, vecs[i].bin);
      check($sformatf("vec%0d req", i),  64'(req),  64'(vecs[i].req));
      check($sformatf("vec%0d done", i), 64'(done), 64'(vecs[i].done));
      check($sformatf("vec%0d ovf", i),  64'(ovf),  64'(vecs[i].ovf));
      check($sformatf("vec%0d err", i),  64'(err),  64'(vecs[i].err));
      check($sformatf("vec%0d cos", i),  64'(cos),  64'(cos_cfg));
    end

    // Aging: hold client 1 ungranted and watch its effective class.
    cycle(1'b1, 8'h00, 1'b0, 3'd0);
    cycle(1'b0, 8'h02, 1'b0, 3'd0);
    check("age req1", 64'(req), 64'h02);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 3'd0);
      if (i == 14) check("age 14 cos", 64'(cos), 64'(cos_cfg));
      if (i >= 15) begin
`ifdef LDL_ROUND_REQ_AGE_EN
        check($sformatf("age %0d cos", i), 64'(cos), 64'(cos_aged));
`else
        check($sformatf("age %0d cos", i), 64'(cos), 64'(cos_cfg));
`endif
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 3'd1);
    check("age grant done", 64'(done), 64'h02);
    check("age grant req",  64'(req),  64'h00);
    check("age grant cos",  64'(cos),  64'(cos_cfg));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
